syscall_unit: RTL and testbench

SYSCALL_UNIT -- requirements
Module: syscall_unit

---
 rtl/syscall_unit_pkg.sv | 14 +
 rtl/syscall_unit_stat_counter.sv | 20 ++
 rtl/syscall_unit.sv | 98 +++++++++
 tb/tb_syscall_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_unit_pkg.sv
// Shared definitions for the syscall unit: default codes, counter width and FSM states.
package syscall_unit_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned SC_SHOW_DEF = 34;
    localparam int unsigned SC_HALT_DEF = 10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/syscall_unit_stat_counter.sv
// Free-running statistics counter: increments by one on inc, wraps modulo 2^W.
module stat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualified events; natural wrap, no overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// Syscall handling unit: display handshake, halt/resume and retire statistics.
module syscall_unit
    import syscall_unit_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned SC_SHOW = SC_SHOW_DEF,
    parameter int unsigned SC_HALT = SC_HALT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             syscall_en,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             resume,
    output logic             stall,
    output logic             halted,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [31:0]      disp_data,
    output logic [CNT_W-1:0] cnt_instr,
    output logic [CNT_W-1:0] cnt_jump,
    output logic [CNT_W-1:0] cnt_btaken
);

    state_t state;
    logic   retire;
    logic   is_show;
    logic   is_halt;

    assign is_show = (v0 == SC_SHOW);
    assign is_halt = (v0 == SC_HALT);

    // Status outputs decode the state register directly.
    always_comb begin
        stall      = (state != ST_RUN);
        halted     = (state == ST_HALT);
        disp_valid = (state == ST_WAIT_ACK);
        retire     = en & ~stall;
    end

    // Control FSM; disp_data is captured only on a SHOW retire so it stays stable while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            disp_data <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (retire && syscall_en) begin
                        if (is_show) begin
                            disp_data <= a0;
                            state     <= ST_WAIT_ACK;
                        end else if (is_halt) begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (disp_ready) begin
                        state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    stat_counter #(.W(CNT_W)) u_cnt_instr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (cnt_instr)
    );

    stat_counter #(.W(CNT_W)) u_cnt_jump (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire & is_jump),
        .count (cnt_jump)
    );

    stat_counter #(.W(CNT_W)) u_cnt_btaken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire & is_branch & branch_taken),
        .count (cnt_btaken)
    );

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table, directed corner cases, random vs model.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, syscall_en, is_jump, is_branch, branch_taken;
    logic [31:0] v0, a0;
    logic        resume, disp_ready;
    logic        stall, halted, disp_valid;
    logic [31:0] disp_data;
    logic [31:0] cnt_instr, cnt_jump, cnt_btaken;

    logic        stall4, halted4, disp_valid4;
    logic [31:0] disp_data4;
    logic [3:0]  ci4, cj4, cb4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    syscall_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .syscall_en(syscall_en),
        .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
        .v0(v0), .a0(a0), .resume(resume), .stall(stall), .halted(halted),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
        .cnt_instr(cnt_instr), .cnt_jump(cnt_jump), .cnt_btaken(cnt_btaken)
    );

    syscall_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .syscall_en(syscall_en),
        .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
        .v0(v0), .a0(a0), .resume(resume), .stall(stall4), .halted(halted4),
        .disp_valid(disp_valid4), .disp_ready(disp_ready), .disp_data(disp_data4),
        .cnt_instr(ci4), .cnt_jump(cj4), .cnt_btaken(cb4)
    );

    typedef struct {
        logic jmp;
        logic br;
        logic tk;
        int   exp_ci;
        int   exp_cj;
        int   exp_cb;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        en = 1'b0; syscall_en = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
        branch_taken = 1'b0; v0 = '0; a0 = '0; resume = 1'b0; disp_ready = 1'b0;
    endtask

    // One clock edge, then settle at the following falling edge for sampling.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural reference: pending display / halted flags plus plain integer counts.
    bit          m_disp_pend, m_halt;
    logic [31:0] m_disp;
    longint      m_ci, m_cj, m_cb;

    task automatic model_step();
        bit busy;
        busy = m_disp_pend || m_halt;
        if (en && !busy) begin
            m_ci++;
            if (is_jump) m_cj++;
            if (is_branch && branch_taken) m_cb++;
            if (syscall_en && v0 == 32'd34) begin
                m_disp_pend = 1'b1;
                m_disp      = a0;
            end else if (syscall_en && v0 == 32'd10) begin
                m_halt = 1'b1;
            end
        end else if (m_disp_pend && disp_ready) begin
            m_disp_pend = 1'b0;
        end else if (m_halt && resume) begin
            m_halt = 1'b0;
        end
    endtask

    initial begin
        int stall_hi;

        vecs[0] = '{1'b1, 1'b0, 1'b0,  1, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1,  2, 1, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b0,  3, 1, 1};
        vecs[3] = '{1'b1, 1'b0, 1'b0,  4, 2, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b0,  5, 2, 1};
        vecs[5] = '{1'b0, 1'b1, 1'b1,  6, 2, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b0,  7, 2, 2};
        vecs[7] = '{1'b1, 1'b0, 1'b0,  8, 3, 2};
        vecs[8] = '{1'b0, 1'b1, 1'b0,  9, 3, 2};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 10, 3, 2};

        // Reset state
        do_reset();
        chk("rst_stall", stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_data", disp_data, 0);
        chk("rst_ci", cnt_instr, 0);

        // Counting table: one retire per record
        for (int unsigned i = 0; i < 10; i++) begin
            en = 1'b1; is_jump = vecs[i].jmp; is_branch = vecs[i].br; branch_taken = vecs[i].tk;
            cyc();
            chk($sformatf("tab_ci[%0d]", i), cnt_instr, vecs[i].exp_ci);
            chk($sformatf("tab_cj[%0d]", i), cnt_jump, vecs[i].exp_cj);
            chk($sformatf("tab_cb[%0d]", i), cnt_btaken, vecs[i].exp_cb);
        end

        // SHOW syscall with delayed acknowledge
        do_reset();
        en = 1'b1; syscall_en = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF; disp_ready = 1'b0;
        cyc();
        stall_hi = 0;
        chk("show_valid", disp_valid, 1);
        chk("show_data", disp_data, 32'hDEADBEEF);
        chk("show_ci", cnt_instr, 1);
        a0 = 32'h12345678;
        for (int unsigned i = 0; i < 3; i++) begin
            if (stall) stall_hi++;
            cyc();
            chk("show_hold_data", disp_data, 32'hDEADBEEF);
            chk("show_hold_ci", cnt_instr, 1);
        end
        if (stall) stall_hi++;
        disp_ready = 1'b1; en = 1'b0;
        cyc();
        if (stall) stall_hi++;
        chk("show_stall_cycles", stall_hi, 4);
        chk("show_done_valid", disp_valid, 0);
        chk("show_done_ci", cnt_instr, 1);
        chk("show_done_data", disp_data, 32'hDEADBEEF);

        // HALT syscall, frozen counters, resume
        do_reset();
        en = 1'b1; syscall_en = 1'b1; v0 = 32'd10; resume = 1'b0;
        cyc();
        chk("halt_halted", halted, 1);
        chk("halt_stall", stall, 1);
        chk("halt_ci", cnt_instr, 1);
        is_jump = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; disp_ready = 1'b1;
        repeat (5) cyc();
        chk("halt_frozen_ci", cnt_instr, 1);
        chk("halt_frozen_cj", cnt_jump, 0);
        chk("halt_frozen_cb", cnt_btaken, 0);
        chk("halt_still", halted, 1);
        idle();
        resume = 1'b1;
        cyc();
        chk("resume_halted", halted, 0);
        chk("resume_stall", stall, 0);

        // Wrap with a 4-bit counter instance
        do_reset();
        en = 1'b1;
        repeat (17) cyc();
        chk("wrap_ci4", ci4, 1);
        chk("wrap_ci32", cnt_instr, 17);

        // Asynchronous reset while waiting for acknowledge
        do_reset();
        en = 1'b1; is_jump = 1'b1;
        cyc();
        syscall_en = 1'b1; v0 = 32'd34; a0 = 32'hCAFEF00D; is_jump = 1'b0;
        cyc();
        chk("arst_pre_valid", disp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", disp_valid, 0);
        chk("arst_stall", stall, 0);
        chk("arst_ci", cnt_instr, 0);
        chk("arst_cj", cnt_jump, 0);
        chk("arst_data", disp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Other syscall code is a no-op except counting
        do_reset();
        en = 1'b1; syscall_en = 1'b1; v0 = 32'd5; a0 = 32'h55; disp_ready = 1'b1;
        cyc();
        chk("noop_stall", stall, 0);
        chk("noop_valid", disp_valid, 0);
        chk("noop_ci", cnt_instr, 1);
        chk("noop_data", disp_data, 0);

        // Random stimulus against the reference model
        do_reset();
        m_disp_pend = 1'b0; m_halt = 1'b0; m_disp = '0; m_ci = 0; m_cj = 0; m_cb = 0;
        for (int unsigned i = 0; i < 2000; i++) begin
            chk("rnd_stall", stall, m_disp_pend || m_halt);
            chk("rnd_halted", halted, m_halt);
            chk("rnd_valid", disp_valid, m_disp_pend);
            chk("rnd_data", disp_data, m_disp);
            chk("rnd_ci", cnt_instr, m_ci % 64'h1_0000_0000);
            chk("rnd_cj", cnt_jump, m_cj % 64'h1_0000_0000);
            chk("rnd_cb", cnt_btaken, m_cb % 64'h1_0000_0000);
            chk("rnd_ci4", ci4, m_ci % 16);
            en           = ($urandom_range(0, 3) != 0);
            syscall_en   = ($urandom_range(0, 3) == 0);
            is_jump      = $urandom_range(0, 1);
            is_branch    = $urandom_range(0, 1);
            branch_taken = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       v0 = 32'd34;
                1:       v0 = 32'd10;
                2:       v0 = 32'd5;
                default: v0 = $urandom;
            endcase
            a0         = $urandom;
            resume     = ($urandom_range(0, 3) == 0);
            disp_ready = $urandom_range(0, 1);
            model_step();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
